prgrom_loader: RTL and testbench
================================

Name: prgrom_loader

Overview:
Writer side of the instruction ROM that the fetch unit reads. It receives a byte stream from an upstream byte source (keypad/serial front end) and assembles little-endian 32-bit instruction words. It writes those words sequentially into the instruction memory's write port. While it loads, it holds the CPU in reset, so fetch restarts at PC 0 once the program is in place.

Parameters:
ADDR_W, 14, word-address width of instruction memory (matches PC[15:2] indexing)
TIMEOUT_CYCLES, 1000000, max clock cycles allowed between bytes once a load has started
CNT_W, 16, width of the word-count header

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  single-cycle pulse; arms a new load (ignored unless in IDLE, DONE or ERR)
byte_valid  input  1  upstream byte present
byte_data  input  8  upstream byte
byte_ready  output  1  loader accepts byte this cycle (byte taken when byte_valid && byte_ready)
mem_we  output  1  instruction memory write enable, one-cycle pulse per word
mem_addr  output  ADDR_W  word address being written
mem_wdata  output  32  word being written
cpu_hold  output  1  high from accepted start until DONE; drives CPU reset
done  output  1  level; load finished successfully
err  output  1  level; load aborted (oversize count or timeout)
words_loaded  output  CNT_W  number of words written in current/last load

Behaviour:
- Reset (async): state=IDLE. Outputs: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0, words_loaded=0. Reset mid-load abandons the load immediately. Memory contents already written are not touched.
- States: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start: go to HDR0. On the same edge: cpu_hold<=1, done<=0, err<=0, words_loaded<=0, mem_addr<=0, byte index<=0, timeout counter<=0.
- byte_ready=1 only in HDR0, HDR1 and DATA. It is 0 in all other states, including WRITE.
- HDR0: accepted byte is count[7:0]. Go to HDR1.
- HDR1: accepted byte is count[15:8]. Then:
  - count==0: go to DONE.
  - count > 2^ADDR_W: go to ERR.
  - otherwise: go to DATA.
- DATA: the byte index (0..3) selects the lane. Byte 0 goes to wdata[7:0] and byte 3 to wdata[31:24] (little-endian). When the 4th byte is accepted, go to WRITE with the assembled word registered on mem_wdata.
- WRITE: lasts exactly one cycle with mem_we=1, mem_addr = current word address and mem_wdata stable. On exit:
  - mem_addr increments. It wraps only when the last legal word is written, which is harmless because the count was bounded in HDR1.
  - words_loaded increments and the byte index resets to 0.
  - If words_loaded+1 == count, go to DONE; else return to DATA.
- Throughput: 4 accepted bytes + 1 write cycle per word. Minimum of 5 cycles/word.
- Timeout: the counter runs in HDR1 and DATA. It clears on every accepted byte. Reaching TIMEOUT_CYCLES-1 without a byte sends the state to ERR. It does not run in HDR0, so the loader waits indefinitely for the first byte.
- DONE: done=1, cpu_hold=0, mem_we=0. words_loaded holds the final count.
- ERR: err=1, cpu_hold=0. words_loaded holds the number of words already written. A partial program may remain in memory.
- start while busy (HDR0..WRITE): ignored.
- byte_valid while byte_ready=0: the byte is not consumed; upstream must hold it.
- byte_valid together with start in IDLE: the byte is not consumed that cycle.

Test Plan:
- Load 2 words: start, then bytes 02 00 | 78 56 34 12 | EF BE AD DE -> mem_we pulses at addr 0 with 0x12345678, then at addr 1 with 0xDEADBEEF. Then done=1, cpu_hold=0, words_loaded=2.
- Zero count: start, then 00 00 -> DONE with no mem_we pulse, words_loaded=0.
- Oversize (ADDR_W=4): count bytes 11 00 (17 words) -> err=1, no write, cpu_hold=0.
- Backpressure: hold byte_valid=1 continuously -> byte_ready=0 for exactly the one WRITE cycle per word, no byte lost or duplicated, 3-word load correct.
- Timeout (TIMEOUT_CYCLES=50): start, header 03 00, one word, then 2 bytes and silence -> ERR after 50 idle cycles, words_loaded=1, mem_we never pulses for word 2.
- Reset mid-load: assert reset during the second word's DATA state -> all outputs are 0 immediately (async). A subsequent start with a full 1-word load succeeds at addr 0.

Source files
------------

// File: rtl/prgrom_loader.sv
// Byte-stream program loader: takes a 16-bit little-endian word count header followed by
// little-endian 32-bit words and writes them sequentially into the instruction memory.
module prgrom_loader #(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  words_loaded
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam longint unsigned MAX_WORDS = 64'd1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [7:0]       count_lo;
    logic [CNT_W-1:0] word_count;
    logic [1:0]       byte_idx;
    logic [23:0]      asm_buf;
    logic [TO_W-1:0]  to_cnt;

    logic             accept;
    logic             timed_out;
    logic             last_word;
    logic [CNT_W-1:0] hdr_count;

    assign accept    = byte_valid && byte_ready;
    assign timed_out = (to_cnt == TO_LAST);
    assign last_word = ((words_loaded + CNT_W'(1)) == word_count);
    assign hdr_count = CNT_W'({byte_data, count_lo});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                done = (state == DONE);
                err  = (state == ERR);
                if (start) begin
                    next_state = HDR0;
                end
            end
            HDR0: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (accept) begin
                    next_state = HDR1;
                end
            end
            HDR1: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (accept) begin
                    if (hdr_count == '0) begin
                        next_state = DONE;
                    end else if (64'(hdr_count) > MAX_WORDS) begin
                        next_state = ERR;
                    end else begin
                        next_state = DATA;
                    end
                end else if (timed_out) begin
                    next_state = ERR;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (accept) begin
                    if (byte_idx == 2'd3) begin
                        next_state = WRITE;
                    end
                end else if (timed_out) begin
                    next_state = ERR;
                end
            end
            WRITE: begin
                mem_we     = 1'b1;
                cpu_hold   = 1'b1;
                next_state = last_word ? DONE : DATA;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: header capture, lane assembly, address/count bookkeeping and the inter-byte timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_lo     <= '0;
            word_count   <= '0;
            byte_idx     <= '0;
            asm_buf      <= '0;
            to_cnt       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        words_loaded <= '0;
                        mem_addr     <= '0;
                        byte_idx     <= '0;
                        to_cnt       <= '0;
                    end
                end
                HDR0: begin
                    if (accept) begin
                        count_lo <= byte_data;
                    end
                end
                HDR1: begin
                    if (accept) begin
                        word_count <= hdr_count;
                        to_cnt     <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                DATA: begin
                    if (accept) begin
                        to_cnt   <= '0;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    asm_buf[7:0]   <= byte_data;
                            2'd1:    asm_buf[15:8]  <= byte_data;
                            2'd2:    asm_buf[23:16] <= byte_data;
                            default: mem_wdata      <= {byte_data, asm_buf};
                        endcase
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                WRITE: begin
                    mem_addr     <= mem_addr + ADDR_W'(1);
                    words_loaded <= words_loaded + CNT_W'(1);
                    byte_idx     <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prgrom_loader.sv
// Self-checking bench for prgrom_loader: table-driven and randomized loads compared against a
// stream-level reference model, plus hand sequences for timeout, busy-start and reset corners.
module tb_prgrom_loader;

    localparam int AW = 4;
    localparam int TO = 50;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [CW-1:0] words_loaded;

    always #5 clock = ~clock;

    prgrom_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    typedef struct {
        int count;
        int gap_max;
        bit exp_done;
        bit exp_err;
        int exp_words;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;
    int ready_low_cnt = 0;

    logic [7:0]    stream_q[$];
    logic [31:0]   exp_data[$];
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];

    // Observed writes and WRITE-cycle backpressure, sampled mid-cycle.
    always @(negedge clock) begin
        if (mem_we) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
        end
        if (cpu_hold && !byte_ready) begin
            ready_low_cnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected end before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_stream(input int count);
        stream_q.delete();
        stream_q.push_back(8'(count));
        stream_q.push_back(8'(count >> 8));
        if (count > 0 && count <= (1 << AW)) begin
            for (int i = 0; i < 4 * count; i++) begin
                stream_q.push_back(8'($urandom));
            end
        end
    endtask

    // Reference model: decode the byte stream into the expected list of written words.
    task automatic model(output bit e_done, output bit e_err);
        int cnt;
        exp_data.delete();
        cnt = int'(stream_q[0]) + 256 * int'(stream_q[1]);
        e_done = 1'b0;
        e_err  = 1'b0;
        if (cnt == 0) begin
            e_done = 1'b1;
        end else if (cnt > (1 << AW)) begin
            e_err = 1'b1;
        end else begin
            e_done = 1'b1;
            for (int i = 0; i < cnt; i++) begin
                exp_data.push_back({stream_q[2+4*i+3], stream_q[2+4*i+2],
                                    stream_q[2+4*i+1], stream_q[2+4*i]});
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic begin_load();
        got_addr.delete();
        got_data.delete();
        ready_low_cnt = 0;
        pulse_start();
        check_output("hold_after_start", 32'(cpu_hold), 32'd1);
    endtask

    // Offer stream_q[from..upto-1] one byte at a time with optional idle gaps.
    task automatic apply_stimulus(input int from, input int upto, input int gap_max);
        int waited;
        for (int i = from; i < upto; i++) begin
            if (gap_max > 0) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) begin
                    @(posedge clock);
                    #1;
                end
            end
            byte_valid = 1'b1;
            byte_data  = stream_q[i];
            waited = 0;
            @(negedge clock);
            while (!byte_ready && waited < 100) begin
                @(negedge clock);
                waited++;
            end
            if (!byte_ready) begin
                check_output("byte_accept", 32'd0, 32'd1);
                byte_valid = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic finish_load(input string tag, input bit e_done, input bit e_err, input int e_words);
        int waited = 0;
        byte_valid = 1'b0;
        @(negedge clock);
        while (!(done || err) && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        check_output({tag, "_done"}, 32'(done), 32'(e_done));
        check_output({tag, "_err"}, 32'(err), 32'(e_err));
        check_output({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check_output({tag, "_words"}, 32'(words_loaded), 32'(e_words));
        check_output({tag, "_nwrites"}, 32'(got_data.size()), 32'(exp_data.size()));
        check_output({tag, "_ready_low"}, 32'(ready_low_cnt), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check_output($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(i % (1 << AW)));
            check_output($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check_output({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check_output({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check_output({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check_output({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_err"}, 32'(err), 32'd0);
        check_output({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        bit   e_done;
        bit   e_err;
        logic [31:0] word0;

        vecs[0] = '{count: 0,     gap_max: 0,  exp_done: 1'b1, exp_err: 1'b0, exp_words: 0};
        vecs[1] = '{count: 17,    gap_max: 0,  exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
        vecs[2] = '{count: 16,    gap_max: 0,  exp_done: 1'b1, exp_err: 1'b0, exp_words: 16};
        vecs[3] = '{count: 65535, gap_max: 0,  exp_done: 1'b0, exp_err: 1'b1, exp_words: 0};
        vecs[4] = '{count: 1,     gap_max: 10, exp_done: 1'b1, exp_err: 1'b0, exp_words: 1};
        vecs[5] = '{count: 5,     gap_max: 40, exp_done: 1'b1, exp_err: 1'b0, exp_words: 5};

        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #12;
        check_all_zero("reset");
        @(posedge clock);
        #1 reset = 1'b0;

        // Two-word load with known bytes.
        stream_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        model(e_done, e_err);
        begin_load();
        apply_stimulus(0, stream_q.size(), 0);
        finish_load("two_word", 1'b1, 1'b0, 2);
        if (got_data.size() == 2) begin
            check_output("two_word_w0", got_data[0], 32'h12345678);
            check_output("two_word_w1", got_data[1], 32'hDEADBEEF);
        end

        for (int v = 0; v < 6; v++) begin
            build_stream(vecs[v].count);
            model(e_done, e_err);
            begin_load();
            apply_stimulus(0, stream_q.size(), vecs[v].gap_max);
            finish_load($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_words);
        end

        for (int r = 0; r < 8; r++) begin
            build_stream($urandom_range(18, 0));
            model(e_done, e_err);
            begin_load();
            apply_stimulus(0, stream_q.size(), $urandom_range(5, 0));
            finish_load($sformatf("rnd%0d", r), e_done, e_err, e_done ? exp_data.size() : 0);
        end

        // No timeout while waiting for the first header byte.
        build_stream(1);
        model(e_done, e_err);
        begin_load();
        repeat (3 * TO) @(posedge clock);
        #1;
        check_output("hdr0_wait_err", 32'(err), 32'd0);
        check_output("hdr0_wait_hold", 32'(cpu_hold), 32'd1);
        apply_stimulus(0, stream_q.size(), 0);
        finish_load("hdr0_wait", 1'b1, 1'b0, 1);

        // start while busy is ignored.
        build_stream(2);
        model(e_done, e_err);
        begin_load();
        apply_stimulus(0, 6, 0);
        pulse_start();
        apply_stimulus(6, stream_q.size(), 0);
        finish_load("busy_start", 1'b1, 1'b0, 2);

        // Timeout after one word plus two bytes of the second.
        build_stream(3);
        word0 = {stream_q[5], stream_q[4], stream_q[3], stream_q[2]};
        begin_load();
        apply_stimulus(0, 8, 0);
        repeat (TO - 1) @(posedge clock);
        #1;
        check_output("timeout_early_err", 32'(err), 32'd0);
        @(posedge clock);
        #1;
        check_output("timeout_err", 32'(err), 32'd1);
        check_output("timeout_hold", 32'(cpu_hold), 32'd0);
        check_output("timeout_words", 32'(words_loaded), 32'd1);
        check_output("timeout_nwrites", 32'(got_data.size()), 32'd1);
        if (got_data.size() >= 1) begin
            check_output("timeout_w0", got_data[0], word0);
        end

        // Asynchronous reset mid-load, then a clean one-word load.
        build_stream(2);
        begin_load();
        apply_stimulus(0, 8, 0);
        #2 reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clock);
        #1 reset = 1'b0;
        build_stream(1);
        model(e_done, e_err);
        begin_load();
        apply_stimulus(0, stream_q.size(), 0);
        finish_load("post_reset", 1'b1, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
